// File: rtl/mutex_pkg.sv
// mutex_pkg
//   Shared definitions for the four-channel mutex client.
//   NUM_REQ_DEF  : number of requester channels (fixed at 4)
//   LEN_W_DEF    : width of the per-job hold length
//   TIMEOUT_DEF  : cycles a channel waits for grant before withdrawing
//   ch_state_t   : 2-bit channel FSM encoding (IDLE, REQ, HOLD, REL)
`timescale 1ns/1ps
package mutex_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_REL  = 2'd3
  } ch_state_t;

endpackage

// File: rtl/mutex_client_ch.sv
// mutex_client_ch
//   One requester channel: accepts a job, requests the shared resource,
//   holds it for the job length, then releases it for one cycle.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     job_valid    : job offered (accepted only while idle)
//     job_len      : hold length of the offered job (0 is treated as 1)
//     grant        : grant line for this channel from the arbiter
//     job_ready    : channel idle, able to accept a job
//     req          : registered request to the arbiter
//     busy         : channel owns the resource (HOLD)
//     done         : one-cycle pulse in the release cycle after a full hold
//     timeout      : one-cycle pulse when the request is abandoned
//     proto_evt    : combinational protocol-violation indication this cycle
`timescale 1ns/1ps
module mutex_client_ch
  import mutex_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  input  logic             grant,
  output logic             job_ready,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             proto_evt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  ch_state_t         state_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  hold_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              job_ready_reg;
  logic              req_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      hold_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      job_ready_reg <= 1'b1;
      req_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      // done and timeout are single-cycle pulses
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (job_valid) begin
            len_reg       <= (job_len == '0) ? LEN_W'(1) : job_len;
            wait_cnt_reg  <= '0;
            req_reg       <= 1'b1;
            job_ready_reg <= 1'b0;
            state_reg     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Grant is checked first so a grant on the final wait cycle wins.
          if (grant) begin
            hold_cnt_reg <= len_reg;
            wait_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_HOLD;
          end else if (wait_cnt_reg + WAIT_W'(1) == WAIT_W'(TIMEOUT)) begin
            // Counter reaches TIMEOUT: req was high for TIMEOUT cycles.
            wait_cnt_reg  <= '0;
            req_reg       <= 1'b0;
            timeout_reg   <= 1'b1;
            job_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!grant) begin
            // Grant withdrawn under us: abandon without done.
            hold_cnt_reg  <= '0;
            req_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            job_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else if (hold_cnt_reg == LEN_W'(1)) begin
            hold_cnt_reg <= '0;
            req_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= ST_REL;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - LEN_W'(1);
          end
        end
        ST_REL: begin
          job_ready_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant is illegal while not requesting, and required while holding.
  assign proto_evt = (grant && (state_reg == ST_IDLE || state_reg == ST_REL)) ||
                     (!grant && state_reg == ST_HOLD);

  assign job_ready = job_ready_reg;
  assign req       = req_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign timeout   = timeout_reg;

endmodule

// File: rtl/mutex_client4.sv
// mutex_client4
//   Four independent mutex-client channels sharing one external arbiter,
//   plus sticky checkers for arbiter misbehaviour.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     job_valid  : per-channel job offered
//     job_len    : per-channel hold length, channel i at [i*LEN_W +: LEN_W]
//     job_ready  : per-channel idle indication
//     req        : registered request lines to the arbiter
//     grant      : grant lines from the arbiter
//     busy       : per-channel resource ownership
//     done       : per-channel release pulse after a full hold
//     timeout    : per-channel abandon pulse
//     err_clr    : clear for the sticky error flags
//     err_proto  : sticky grant-protocol violation
//     err_mutex  : sticky multiple-grant violation
`timescale 1ns/1ps
module mutex_client4
  import mutex_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       job_valid,
  input  logic [NUM_REQ*LEN_W-1:0] job_len,
  output logic [NUM_REQ-1:0]       job_ready,
  output logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       busy,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       timeout,
  input  logic                     err_clr,
  output logic                     err_proto,
  output logic                     err_mutex
);

  logic [NUM_REQ-1:0] proto_evt;
  logic               mutex_evt;
  logic               err_proto_reg;
  logic               err_mutex_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ch
      mutex_client_ch #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid[gi]),
        .job_len   (job_len[gi*LEN_W +: LEN_W]),
        .grant     (grant[gi]),
        .job_ready (job_ready[gi]),
        .req       (req[gi]),
        .busy      (busy[gi]),
        .done      (done[gi]),
        .timeout   (timeout[gi]),
        .proto_evt (proto_evt[gi])
      );
    end
  endgenerate

  assign mutex_evt = ($countones(grant) > 1);

  // A new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_proto_reg <= 1'b0;
      err_mutex_reg <= 1'b0;
    end else begin
      err_proto_reg <= (err_proto_reg && !err_clr) || (|proto_evt);
      err_mutex_reg <= (err_mutex_reg && !err_clr) || mutex_evt;
    end
  end

  assign err_proto = err_proto_reg;
  assign err_mutex = err_mutex_reg;

endmodule
